// File: rtl/spi_frame_master_if.sv
// spi_frame_master_if: frame request/response handshake plus the SPI slave pins
interface spi_frame_master_if #(parameter int FRAME_BITS = 80);
  logic start;
  logic [FRAME_BITS-1:0] tx_frame;
  logic busy;
  logic done;
  logic [FRAME_BITS-1:0] rx_frame;
  logic sck;
  logic mosi;
  logic miso;
  logic fpga_cs;
  modport master (input start, tx_frame, miso, output busy, done, rx_frame, sck, mosi, fpga_cs);
  modport slave (output start, tx_frame, miso, input busy, done, rx_frame, sck, mosi, fpga_cs);
endinterface

// File: rtl/spi_frame_master.sv
// spi_frame_master: one-frame SPI master, all four modes, either bit order, timed chip select
module spi_frame_master #(
  parameter int FRAME_BITS = 80,
  parameter int CLK_DIV = 4,
  parameter int CS_SETUP = 5,
  parameter int CS_HOLD = 5,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk_8mhz,
  input logic reset_n,
  spi_frame_master_if.master bus
);
  localparam int SH_MAX = CS_SETUP > CS_HOLD ? CS_SETUP : CS_HOLD;
  localparam int SW = SH_MAX > 1 ? $clog2(SH_MAX) : 1;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(2 * FRAME_BITS);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state, state_n;
  logic [SW-1:0] cnt;
  logic [DW-1:0] div;
  logic [HW-1:0] half;
  logic [FRAME_BITS-1:0] sr, rx;
  logic tick, last, lead, adv, cap, cnt_end;
  function automatic logic first_bit(input logic [FRAME_BITS-1:0] v);
    return MSB_FIRST ? v[FRAME_BITS-1] : v[0];
  endfunction
  function automatic logic [FRAME_BITS-1:0] advance(input logic [FRAME_BITS-1:0] v);
    return MSB_FIRST ? v << 1 : v >> 1;
  endfunction
  // half counts sck toggles; even toggles are leading edges, odd ones trailing
  always_comb begin
    tick = state == SHIFT && div == DW'(CLK_DIV - 1);
    last = tick && half == HW'(2 * FRAME_BITS - 1);
    lead = tick && !half[0];
    adv = CPHA ? lead : tick && half[0] && !last;
    cap = CPHA ? tick && half[0] : lead;
    cnt_end = cnt == SW'((state == SETUP ? CS_SETUP : CS_HOLD) - 1);
    state_n = state == IDLE ? (bus.start ? SETUP : IDLE) :
              state == SETUP ? (cnt_end ? SHIFT : SETUP) :
              state == SHIFT ? (last ? HOLD : SHIFT) : (cnt_end ? IDLE : HOLD);
  end
  always_ff @(posedge clk_8mhz) state <= !reset_n ? IDLE : state_n;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk_8mhz) begin
    if (!reset_n) begin
      cnt <= '0;
      div <= '0;
      half <= '0;
      sr <= '0;
      rx <= '0;
      bus.rx_frame <= '0;
      bus.done <= 1'b0;
      bus.sck <= CPOL;
      bus.mosi <= 1'b0;
      bus.fpga_cs <= 1'b1;
    end else begin
      cnt <= (state == state_n && (state == SETUP || state == HOLD)) ? cnt + 1'b1 : '0;
      div <= (state == SHIFT && !tick) ? div + 1'b1 : '0;
      half <= (state == SHIFT && !last) ? half + HW'(tick) : '0;
      bus.done <= state == HOLD && cnt_end;
      if (tick) bus.sck <= ~bus.sck;
      if (cap) rx <= MSB_FIRST ? ((rx << 1) | FRAME_BITS'(bus.miso)) : ((rx >> 1) | (FRAME_BITS'(bus.miso) << (FRAME_BITS - 1)));
      if (adv) begin
        bus.mosi <= first_bit(sr);
        sr <= advance(sr);
      end
      // CPHA=0 puts the first bit out during SETUP, so only the remainder stays queued
      if (state == IDLE && bus.start) begin
        sr <= CPHA ? bus.tx_frame : advance(bus.tx_frame);
        bus.mosi <= CPHA ? 1'b0 : first_bit(bus.tx_frame);
        rx <= '0;
        bus.fpga_cs <= 1'b0;
      end
      if (state == HOLD && cnt_end) begin
        bus.fpga_cs <= 1'b1;
        bus.mosi <= 1'b0;
        bus.rx_frame <= rx;
      end
    end
  end
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: three parameter sets muxed onto one monitor, checked against frame-level rules
module tb_spi_frame_master;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  spi_frame_master_if #(.FRAME_BITS(80)) ia();
  spi_frame_master_if #(.FRAME_BITS(8)) ib();
  spi_frame_master_if #(.FRAME_BITS(16)) ic();
  spi_frame_master da (.clk_8mhz(clk), .reset_n(reset_n), .bus(ia.master));
  spi_frame_master #(.FRAME_BITS(8), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1)) db (.clk_8mhz(clk), .reset_n(reset_n), .bus(ib.master));
  spi_frame_master #(.FRAME_BITS(16), .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(3), .CPHA(1'b1), .MSB_FIRST(1'b0)) dc (.clk_8mhz(clk), .reset_n(reset_n), .bus(ic.master));
  int cur, fb, cd, css, csh, errors, checks;
  bit cpol, cpha, msb, loop;
  logic g_start, drv, clr;
  logic [79:0] g_tx, tx_exp, rvv;
  logic g_sck, g_mosi, g_cs, g_busy, g_done;
  logic [79:0] g_rx;
  assign ia.start = g_start && cur == 0;
  assign ib.start = g_start && cur == 1;
  assign ic.start = g_start && cur == 2;
  assign ia.tx_frame = g_tx;
  assign ib.tx_frame = g_tx[7:0];
  assign ic.tx_frame = g_tx[15:0];
  assign ia.miso = loop ? ia.mosi : drv;
  assign ib.miso = loop ? ib.mosi : drv;
  assign ic.miso = loop ? ic.mosi : drv;
  always_comb begin
    g_sck = cur == 0 ? ia.sck : cur == 1 ? ib.sck : ic.sck;
    g_mosi = cur == 0 ? ia.mosi : cur == 1 ? ib.mosi : ic.mosi;
    g_cs = cur == 0 ? ia.fpga_cs : cur == 1 ? ib.fpga_cs : ic.fpga_cs;
    g_busy = cur == 0 ? ia.busy : cur == 1 ? ib.busy : ic.busy;
    g_done = cur == 0 ? ia.done : cur == 1 ? ib.done : ic.done;
    g_rx = cur == 0 ? ia.rx_frame : cur == 1 ? {72'd0, ib.rx_frame} : {64'd0, ic.rx_frame};
  end
  // k-th bit on the wire in transmission order
  function automatic logic bitsel(input logic [79:0] v, input int k);
    return msb ? v[fb-1-k] : v[k];
  endfunction
  function automatic logic [79:0] rnd();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0] & ((80'd1 << fb) - 80'd1);
  endfunction
  int cyc, nsamp, mosi_bad, mchg_bad, nrise, rise_bad, lrise, brun, blen, dcnt, done_bad, dgap, ldone, chi, csgap, cs_bad, idle_bad, rx_bad;
  logic psck, pmosi, pbusy, pcs, rstq;
  logic [79:0] prx;
  logic tog, lead_e, samp, drv_e;
  always_comb begin
    tog = g_sck != psck;
    lead_e = tog && g_sck != cpol;
    samp = tog && (cpha ? !lead_e : lead_e);
    drv_e = tog && (cpha ? lead_e : !lead_e);
  end
  always @(negedge clk) begin
    psck <= g_sck;
    pmosi <= g_mosi;
    pbusy <= g_busy;
    pcs <= g_cs;
    prx <= g_rx;
    rstq <= !reset_n;
    cyc <= cyc + 1;
    if (clr) begin
      nsamp <= 0; mosi_bad <= 0; mchg_bad <= 0; nrise <= 0; rise_bad <= 0; lrise <= -1;
      brun <= 0; blen <= 0; dcnt <= 0; done_bad <= 0; dgap <= 0; ldone <= cyc;
      chi <= 0; csgap <= 0; cs_bad <= 0; idle_bad <= 0; rx_bad <= 0;
      drv <= bitsel(rvv, 0);
    end else begin
      if (samp) begin
        if (g_mosi !== bitsel(tx_exp, nsamp % fb)) mosi_bad <= mosi_bad + 1;
        nsamp <= nsamp + 1;
        drv <= bitsel(rvv, (nsamp + 1) % fb);
      end
      if (g_busy && pbusy && g_mosi !== pmosi && !drv_e) mchg_bad <= mchg_bad + 1;
      if (tog && g_sck) begin
        nrise <= nrise + 1;
        if (lrise >= 0 && cyc - lrise != 2 * cd) rise_bad <= rise_bad + 1;
      end
      lrise <= !g_busy ? -1 : (tog && g_sck) ? cyc : lrise;
      if (g_busy) brun <= brun + 1;
      else if (pbusy) begin
        blen <= brun;
        brun <= 0;
      end
      if (g_done) begin
        dcnt <= dcnt + 1;
        if (g_busy || !pbusy) done_bad <= done_bad + 1;
        dgap <= cyc - ldone;
        ldone <= cyc;
      end
      if (g_cs !== !g_busy) cs_bad <= cs_bad + 1;
      if (g_cs) chi <= chi + 1;
      else if (pcs) begin
        csgap <= chi;
        chi <= 0;
      end
      if (!g_busy && (g_sck !== cpol || g_mosi !== 1'b0)) idle_bad <= idle_bad + 1;
      if (!rstq && g_rx !== prx && !g_done) rx_bad <= rx_bad + 1;
    end
  end
  task automatic sel(input int i);
    cur = i;
    fb = i == 0 ? 80 : i == 1 ? 8 : 16;
    cd = i == 0 ? 4 : i == 1 ? 1 : 2;
    css = i == 2 ? 1 : 5;
    csh = i == 2 ? 3 : 5;
    cpol = i == 1;
    cpha = i != 0;
    msb = i != 2;
  endtask
  task automatic prep(input int i, input logic [79:0] tx, input logic [79:0] rv, input bit lp);
    @(posedge clk); #1;
    sel(i);
    tx_exp = tx;
    rvv = rv;
    loop = lp;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask
  task automatic kick(input logic [79:0] tx);
    g_tx = tx;
    g_start = 1'b1;
    @(posedge clk); #1;
    g_start = 1'b0;
    g_tx = rnd();
  endtask
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (g_done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #1;
    checks++; if (g_done !== 1'b1) begin errors++; $display("FAIL %s done_timeout: got %b want 1", nm, g_done); end
  endtask
  task automatic test_reset();
    reset_n = 1'b0; g_start = 1'b0; clr = 1'b0; loop = 1'b0; g_tx = '0; drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel(i);
      #1;
      checks++; if (g_busy !== 1'b0) begin errors++; $display("FAIL reset%0d busy: got %b want 0", i, g_busy); end
      checks++; if (g_cs !== 1'b1) begin errors++; $display("FAIL reset%0d cs: got %b want 1", i, g_cs); end
      checks++; if (g_sck !== cpol) begin errors++; $display("FAIL reset%0d sck: got %b want %b", i, g_sck, cpol); end
      checks++; if (g_mosi !== 1'b0) begin errors++; $display("FAIL reset%0d mosi: got %b want 0", i, g_mosi); end
      checks++; if (g_done !== 1'b0) begin errors++; $display("FAIL reset%0d done: got %b want 0", i, g_done); end
      checks++; if (g_rx !== 80'd0) begin errors++; $display("FAIL reset%0d rx: got %h want 0", i, g_rx); end
    end
    reset_n = 1'b1;
  endtask
  task automatic test_frame(input string nm, input int i, input logic [79:0] tx, input logic [79:0] rv, input bit lp);
    int t;
    logic [79:0] want;
    prep(i, tx, rv, lp);
    kick(tx);
    wait_done(nm);
    t = css + 2 * fb * cd + csh;
    want = lp ? tx : rv;
    checks++; if (g_rx !== want) begin errors++; $display("FAIL %s rx_frame: got %h want %h", nm, g_rx, want); end
    checks++; if (blen != t) begin errors++; $display("FAIL %s busy_len: got %0d want %0d", nm, blen, t); end
    checks++; if (nrise != fb) begin errors++; $display("FAIL %s sck_rises: got %0d want %0d", nm, nrise, fb); end
    checks++; if (rise_bad != 0) begin errors++; $display("FAIL %s sck_period: got %0d bad want 0", nm, rise_bad); end
    checks++; if (nsamp != fb) begin errors++; $display("FAIL %s sample_edges: got %0d want %0d", nm, nsamp, fb); end
    checks++; if (mosi_bad != 0) begin errors++; $display("FAIL %s mosi_bits: got %0d wrong want 0", nm, mosi_bad); end
    checks++; if (mchg_bad != 0) begin errors++; $display("FAIL %s mosi_edge: got %0d stray changes want 0", nm, mchg_bad); end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL %s done_count: got %0d want 1", nm, dcnt); end
    checks++; if (done_bad != 0) begin errors++; $display("FAIL %s done_timing: got %0d bad want 0", nm, done_bad); end
    checks++; if (cs_bad != 0) begin errors++; $display("FAIL %s cs_vs_busy: got %0d bad want 0", nm, cs_bad); end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL %s idle_pins: got %0d bad want 0", nm, idle_bad); end
    checks++; if (rx_bad != 0) begin errors++; $display("FAIL %s rx_stable: got %0d bad want 0", nm, rx_bad); end
  endtask
  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      sel(r % 3);
      test_frame("random", r % 3, rnd(), rnd(), 1'($urandom_range(0, 1)));
    end
  endtask
  task automatic test_midframe_start();
    logic [79:0] tx;
    sel(0);
    tx = rnd();
    prep(0, tx, tx, 1'b1);
    kick(tx);
    repeat (css + 20 * cd) @(posedge clk);
    #1;
    g_start = 1'b1;
    g_tx = ~tx;
    @(posedge clk); #1;
    g_start = 1'b0;
    wait_done("midstart");
    checks++; if (g_rx !== tx) begin errors++; $display("FAIL midstart rx_frame: got %h want %h", g_rx, tx); end
    checks++; if (mosi_bad != 0) begin errors++; $display("FAIL midstart mosi_bits: got %0d wrong want 0", mosi_bad); end
    checks++; if (nsamp != fb) begin errors++; $display("FAIL midstart sample_edges: got %0d want %0d", nsamp, fb); end
    repeat (40) @(negedge clk);
    #1;
    checks++; if (dcnt != 1) begin errors++; $display("FAIL midstart done_count: got %0d want 1", dcnt); end
    checks++; if (g_busy !== 1'b0) begin errors++; $display("FAIL midstart busy_after: got %b want 0", g_busy); end
  endtask
  task automatic test_reset_midframe();
    logic [79:0] tx;
    sel(0);
    tx = rnd();
    prep(0, tx, tx, 1'b1);
    kick(tx);
    repeat (css + 30 * cd) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (g_cs !== 1'b1) begin errors++; $display("FAIL abort cs: got %b want 1", g_cs); end
    checks++; if (g_sck !== cpol) begin errors++; $display("FAIL abort sck: got %b want %b", g_sck, cpol); end
    checks++; if (g_busy !== 1'b0) begin errors++; $display("FAIL abort busy: got %b want 0", g_busy); end
    checks++; if (g_rx !== 80'd0) begin errors++; $display("FAIL abort rx_frame: got %h want 0", g_rx); end
    repeat (700) @(negedge clk);
    #1;
    checks++; if (dcnt != 0) begin errors++; $display("FAIL abort done_count: got %0d want 0", dcnt); end
    checks++; if (g_rx !== 80'd0) begin errors++; $display("FAIL abort rx_after: got %h want 0", g_rx); end
    test_frame("after_abort", 0, rnd(), rnd(), 1'b0);
  endtask
  task automatic test_back_to_back();
    logic [79:0] tx, rv;
    int t;
    sel(1);
    tx = rnd();
    rv = rnd();
    t = css + 2 * fb * cd + csh;
    prep(1, tx, rv, 1'b0);
    g_tx = tx;
    g_start = 1'b1;
    wait_done("b2b_first");
    @(posedge clk); #1;
    g_start = 1'b0;
    wait_done("b2b_second");
    checks++; if (dcnt != 2) begin errors++; $display("FAIL b2b done_count: got %0d want 2", dcnt); end
    checks++; if (dgap != t + 1) begin errors++; $display("FAIL b2b done_gap: got %0d want %0d", dgap, t + 1); end
    checks++; if (csgap != 1) begin errors++; $display("FAIL b2b cs_gap: got %0d want 1", csgap); end
    checks++; if (blen != t) begin errors++; $display("FAIL b2b busy_len: got %0d want %0d", blen, t); end
    checks++; if (g_rx !== rv) begin errors++; $display("FAIL b2b rx_frame: got %h want %h", g_rx, rv); end
    checks++; if (mosi_bad != 0) begin errors++; $display("FAIL b2b mosi_bits: got %0d wrong want 0", mosi_bad); end
    checks++; if (nsamp != 2 * fb) begin errors++; $display("FAIL b2b sample_edges: got %0d want %0d", nsamp, 2 * fb); end
    checks++; if (done_bad != 0) begin errors++; $display("FAIL b2b done_timing: got %0d bad want 0", done_bad); end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    sel(0);
    test_reset();
    test_frame("loopback_default", 0, 80'h80FF00FF000000000000, 80'h80FF00FF000000000000, 1'b1);
    test_frame("mode3_div1", 1, 80'hA5, 80'hFF, 1'b0);
    test_frame("lsb_first", 2, 80'h1, 80'h1, 1'b1);
    test_random();
    test_midframe_start();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
